adder_rr_arbiter: RTL and testbench

ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

---
 rtl/adder_arb_pkg.sv | 24 ++
 rtl/adder_rr_arbiter_number_adder.sv | 19 +
 rtl/adder_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_adder_rr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin shared-adder block.
package adder_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Index width for n entries. The result is never below 1, so an
  // index port always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_number_adder.sv
// Shared datapath: WIDTH-bit add with carry in and carry out.
module number_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full;

  // One extra bit keeps the carry, so the sum is exact modulo 2^(WIDTH+1).
  assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter in front of a single shared adder.
// Flow: IDLE (grant + capture) -> CALC (add + register) -> RESP (hold until taken).
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]         req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [clog2(N_REQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
);

  localparam int IDX_W = clog2(N_REQ);

  state_e                        state_q;
  logic [IDX_W-1:0]              last_grant_q;
  logic [N_REQ-1:0][WIDTH-1:0]   a_vec;
  logic [N_REQ-1:0][WIDTH-1:0]   b_vec;
  logic [WIDTH-1:0]              op_a_q;
  logic [WIDTH-1:0]              op_b_q;
  logic                          op_cin_q;
  logic [IDX_W-1:0]              op_id_q;
  logic [IDX_W-1:0]              cand;
  logic [IDX_W-1:0]              sel_idx;
  logic                          sel_found;
  logic [WIDTH-1:0]              add_sum;
  logic                          add_cout;

  // Flat operand buses viewed as per-requester lanes.
  assign a_vec = req_a;
  assign b_vec = req_b;

  // Round-robin search: first valid requester after last_grant, wrapping.
  // Untouched requesters keep their place since only a grant moves last_grant.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % N_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // One-hot accept, only offered in IDLE and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && sel_found) req_ready[sel_idx] = 1'b1;
  end

  number_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (op_cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Control FSM with registered response and status outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      op_id_q      <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            op_a_q       <= a_vec[sel_idx];
            op_b_q       <= b_vec[sel_idx];
            op_cin_q     <= req_cin[sel_idx];
            op_id_q      <= sel_idx;
            last_grant_q <= sel_idx;
            busy         <= 1'b1;
            state_q      <= CALC;
          end
        end
        CALC: begin
          rsp_sum   <= add_sum;
          rsp_cout  <= add_cout;
          rsp_id    <= op_id_q;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized self-checking bench for adder_rr_arbiter.
module tb_adder_rr_arbiter;
  import adder_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N-1:0]    req_cin = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_sum;
  logic            rsp_cout;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int model_last = N - 1;

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];
  logic [N-1:0] cin_v;

  adder_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_arr[i];
      req_b[i*W +: W] = b_arr[i];
    end
    req_cin = cin_v;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = $urandom;
      b_arr[i] = $urandom;
      cin_v[i] = 1'($urandom_range(0, 1));
    end
    drive_ops();
  endtask

  // Reference rule: first valid requester after the previous grant, wrapping.
  function automatic int model_grant(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(model_last + k) % N]) return (model_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W:0] model_sum(input int i);
    return {1'b0, a_arr[i]} + {1'b0, b_arr[i]} + {{W{1'b0}}, cin_v[i]};
  endfunction

  // Issue one request mask from IDLE, collect the response, return to IDLE.
  task automatic run_txn(input logic [N-1:0] m, input int stall, output int gid,
                         output int rid, output logic [W-1:0] s, output logic c,
                         output bit ok);
    int n;
    ok = 1'b1;
    gid = -1;
    req_valid = m;
    rsp_ready = (stall == 0);
    #1;
    if ($onehot(req_ready)) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
    end
    @(posedge clock); #1;
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    if (!rsp_valid) ok = 1'b0;
    rid = int'(rsp_id);
    s   = rsp_sum;
    c   = rsp_cout;
    if (ok) begin
      repeat (stall) begin @(posedge clock); #1; end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    #12;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 ||
        rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b sum=%0h cout=%b id=%0d want all zero",
               rsp_valid, busy, req_ready, rsp_sum, rsp_cout, rsp_id);
    end
    req_valid = '0;
    @(posedge clock); #1;
    rst_n = 1'b1;
    model_last = N - 1;
  endtask

  task automatic test_single();
    a_arr[2] = 32'd5; b_arr[2] = 32'd7; cin_v = 4'b0100;
    drive_ops();
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    @(posedge clock); #1;
    req_valid = '0;
    total++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_edge1: busy=%b valid=%b want 1 0", busy, rsp_valid);
    end
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'd13 || rsp_cout !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp: valid=%b id=%0d sum=%0d cout=%b want 1 2 13 0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
    @(posedge clock); #1;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_done: busy=%b valid=%b want 0 0", busy, rsp_valid);
    end
    model_last = 2;
  endtask

  task automatic test_reset_mid_resp();
    int n;
    rand_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    @(posedge clock); #1;
    req_valid = '1;
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL midreset_in_resp: valid=%b want 1", rsp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 ||
        rsp_sum !== '0 || rsp_id !== '0 || rsp_cout !== 1'b0) begin
      bad++;
      $display("FAIL midreset_clear: valid=%b busy=%b ready=%b sum=%0h id=%0d want zeros",
               rsp_valid, busy, req_ready, rsp_sum, rsp_id);
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL midreset_first_grant: got %b want 0001", req_ready);
    end
    @(posedge clock); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clock); #1; n++; end
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || {rsp_cout, rsp_sum} !== model_sum(0)) begin
      bad++;
      $display("FAIL midreset_rsp: valid=%b id=%0d sum=%0h want 1 0 %0h",
               rsp_valid, rsp_id, {rsp_cout, rsp_sum}, model_sum(0));
    end
    @(posedge clock); #1;
    model_last = 0;
  endtask

  task automatic test_fairness();
    int gid, rid; logic [W-1:0] s; logic c; bit ok;
    rst_n = 1'b0;
    #2;
    @(posedge clock); #1;
    rst_n = 1'b1;
    model_last = N - 1;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      run_txn(4'b1111, 0, gid, rid, s, c, ok);
      total++;
      if (!ok || gid != i % N || rid != i % N || {c, s} !== model_sum(i % N)) begin
        bad++;
        $display("FAIL fairness[%0d]: ok=%0d grant=%0d id=%0d sum=%0h want id %0d sum %0h",
                 i, ok, gid, rid, {c, s}, i % N, model_sum(i % N));
      end
      model_last = i % N;
    end
  endtask

  task automatic test_backpressure();
    int exp; logic [IW-1:0] id0; logic [W-1:0] s0; logic c0; int extra;
    rand_ops();
    exp = model_grant(4'b1010);
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    @(posedge clock); #1;
    req_valid = '1;
    @(posedge clock); #1;
    id0 = rsp_id; s0 = rsp_sum; c0 = rsp_cout;
    total++;
    if (rsp_valid !== 1'b1 || int'(id0) != exp || {c0, s0} !== model_sum(exp)) begin
      bad++;
      $display("FAIL bp_rsp: valid=%b id=%0d sum=%0h want 1 %0d %0h",
               rsp_valid, id0, {c0, s0}, exp, model_sum(exp));
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_sum !== s0 || rsp_cout !== c0 ||
          req_ready !== '0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: valid=%b id=%0d sum=%0h ready=%b busy=%b",
                 i, rsp_valid, rsp_id, rsp_sum, req_ready, busy);
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release: valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    extra = 0;
    repeat (4) begin @(posedge clock); #1; if (rsp_valid) extra++; end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL bp_single_rsp: extra responses=%0d want 0", extra);
    end
    model_last = exp;
  endtask

  task automatic test_overflow();
    int gid, rid; logic [W-1:0] s; logic c; bit ok;
    a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 32'h0000_0001; cin_v = 4'b0000;
    drive_ops();
    run_txn(4'b0001, 0, gid, rid, s, c, ok);
    total++;
    if (!ok || rid != 0 || s !== 32'h0 || c !== 1'b1) begin
      bad++; $display("FAIL overflow_wrap: ok=%0d id=%0d sum=%0h cout=%b want 0 0 1", ok, rid, s, c);
    end
    model_last = 0;
    a_arr[3] = 32'hFFFF_FFFF; b_arr[3] = 32'hFFFF_FFFF; cin_v = 4'b1000;
    drive_ops();
    run_txn(4'b1000, 1, gid, rid, s, c, ok);
    total++;
    if (!ok || rid != 3 || s !== 32'hFFFF_FFFF || c !== 1'b1) begin
      bad++; $display("FAIL overflow_full: ok=%0d id=%0d sum=%0h cout=%b want 3 ffffffff 1", ok, rid, s, c);
    end
    model_last = 3;
  endtask

  task automatic test_sole();
    int gid, rid; logic [W-1:0] s; logic c; bit ok;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      run_txn(4'b0100, 0, gid, rid, s, c, ok);
      total++;
      if (!ok || gid != 2 || rid != 2 || {c, s} !== model_sum(2)) begin
        bad++; $display("FAIL sole[%0d]: grant=%0d id=%0d sum=%0h want 2 %0h", i, gid, rid, {c, s}, model_sum(2));
      end
      model_last = 2;
    end
  endtask

  task automatic test_random();
    int gid, rid, exp; logic [W-1:0] s; logic c; bit ok; logic [N-1:0] m;
    for (int i = 0; i < 1000; i++) begin
      rand_ops();
      m = N'($urandom_range(1, (1 << N) - 1));
      exp = model_grant(m);
      run_txn(m, $urandom_range(0, 3), gid, rid, s, c, ok);
      total++;
      if (!ok || gid != exp || rid != exp || {c, s} !== model_sum(exp)) begin
        bad++;
        $display("FAIL random[%0d]: mask=%b ok=%0d grant=%0d id=%0d sum=%0h want %0d %0h",
                 i, m, ok, gid, rid, {c, s}, exp, model_sum(exp));
      end
      model_last = exp;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    cin_v = '0;
    test_reset();
    test_single();
    test_reset_mid_resp();
    test_fairness();
    test_backpressure();
    test_overflow();
    test_sole();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
